// File: rtl/approx_mult_pkg.sv
// Shared constants and helpers for the approximate multiplier pipeline.
package approx_mult_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  localparam int unsigned WIDTH_MIN = 4;
  localparam int unsigned WIDTH_MAX = 16;

  function automatic int unsigned cols_max(input int unsigned width);
    return 2 * width;
  endfunction

  // Number of partial-product bits that land in product column c.
  function automatic int unsigned col_height(input int unsigned c, input int unsigned width);
    if (c >= 2 * width - 1) return 0;
    else if (c < width)     return c + 1;
    else                    return 2 * width - 1 - c;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_if.sv
// Operand/result handshake bundle for approx_mult_pipe.
interface approx_mult_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic               out_mode;
  logic [15:0]        approx_count;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_p, out_mode, approx_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_p, out_mode, approx_count
  );
endinterface

// File: rtl/approx_col_reducer.sv
// Reduces the partial-product array to a sum/carry pair; low columns are
// XOR-only in approximate mode and neither generate nor receive carries.
module approx_col_reducer
  import approx_mult_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_COLS = 4
) (
  input  logic [WIDTH-1:0]   pp [WIDTH],
  input  logic               mode,
  output logic [2*WIDTH-1:0] sum,
  output logic [2*WIDTH-1:0] carry
);
  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0] keep, low, s, c, row, maj;

  // Rows are masked to the exact columns before the carry-save chain, so
  // carries only ever move upward from column APPROX_COLS.
  always_comb begin
    keep = (mode == MODE_APPROX) ? ({PW{1'b1}} << APPROX_COLS) : '1;
    low  = '0;
    s    = '0;
    c    = '0;
    row  = '0;
    maj  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        if (mode == MODE_APPROX && (i + k) < APPROX_COLS)
          low[i+k] = low[i+k] ^ pp[i][k];
      end
      row = (PW'(pp[i]) << i) & keep;
      maj = (s & c) | (s & row) | (c & row);
      s   = s ^ c ^ row;
      c   = maj << 1;
    end
    sum   = s | low;
    carry = c;
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage valid/ready multiplier with per-transaction exact or
// approximate low-column reduction and a saturating approx-result counter.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_COLS = 4
) (
  input logic               clk,
  input logic               rst_n,
  approx_mult_pipe_if.slave bus
);
  localparam int unsigned PW = 2 * WIDTH;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("approx_mult_pipe: WIDTH out of range 4..16");
  end
  if (APPROX_COLS > cols_max(WIDTH)) begin : g_cols_check
    $error("approx_mult_pipe: APPROX_COLS exceeds 2*WIDTH");
  end

  logic             v1, v2, v3;
  logic [WIDTH-1:0] a1, b1;
  logic             m1, m2, m3;
  logic [PW-1:0]    s2, c2, p3;
  logic [15:0]      count;
  logic             adv1, adv2, adv3;

  logic [WIDTH-1:0] pp [WIDTH];
  logic [PW-1:0]    red_sum, red_carry;

  assign adv3 = !v3 || bus.out_ready;
  assign adv2 = !v2 || adv3;
  assign adv1 = !v1 || adv2;

  assign bus.in_ready     = adv1;
  assign bus.out_valid    = v3;
  assign bus.out_p        = p3;
  assign bus.out_mode     = m3;
  assign bus.approx_count = count;

  always_comb begin
    pp = '{default: '0};
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        pp[i][k] = a1[k] & b1[i];
      end
    end
  end

  approx_col_reducer #(
    .WIDTH       (WIDTH),
    .APPROX_COLS (APPROX_COLS)
  ) u_reducer (
    .pp    (pp),
    .mode  (m1),
    .sum   (red_sum),
    .carry (red_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      m1    <= 1'b0;
      s2    <= '0;
      c2    <= '0;
      m2    <= 1'b0;
      p3    <= '0;
      m3    <= 1'b0;
      count <= '0;
    end else begin
      if (adv1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          a1 <= bus.in_a;
          b1 <= bus.in_b;
          m1 <= bus.in_mode;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          s2 <= red_sum;
          c2 <= red_carry;
          m2 <= m1;
        end
      end
      if (adv3) begin
        v3 <= v2;
        if (v2) begin
          p3 <= s2 + c2;
          m3 <= m2;
        end
      end
      if (v3 && bus.out_ready && m3 == MODE_APPROX && count != '1)
        count <= count + 16'd1;
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Scoreboard bench: three approx_mult_pipe instances (APPROX_COLS 0/4/16) in lockstep.
module tb_approx_mult_pipe;

  typedef struct {
    logic [15:0] e0;
    logic [15:0] e4;
    logic [15:0] e16;
    logic        mode;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic        rand_bp = 1'b0;
  logic [15:0] model_cnt = '0;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned n_accepted = 0;
  int unsigned n_pop = 0;
  sb_t         sb [$];

  always #5 clk = ~clk;

  approx_mult_pipe_if #(.WIDTH(8)) bus0 ();
  approx_mult_pipe_if #(.WIDTH(8)) bus4 ();
  approx_mult_pipe_if #(.WIDTH(8)) bus16 ();

  assign bus0.in_valid  = in_valid;  assign bus0.in_a  = in_a;  assign bus0.in_b  = in_b;
  assign bus0.in_mode   = in_mode;   assign bus0.out_ready  = out_ready;
  assign bus4.in_valid  = in_valid;  assign bus4.in_a  = in_a;  assign bus4.in_b  = in_b;
  assign bus4.in_mode   = in_mode;   assign bus4.out_ready  = out_ready;
  assign bus16.in_valid = in_valid;  assign bus16.in_a = in_a;  assign bus16.in_b = in_b;
  assign bus16.in_mode  = in_mode;   assign bus16.out_ready = out_ready;

  approx_mult_pipe #(.WIDTH(8), .APPROX_COLS(0))  u_dut0  (.clk(clk), .rst_n(rst_n), .bus(bus0));
  approx_mult_pipe #(.WIDTH(8), .APPROX_COLS(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  approx_mult_pipe #(.WIDTH(8), .APPROX_COLS(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bit-level reference: column XOR below cols, plain weighted sum above.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic mode, input int unsigned cols);
    logic [31:0] hi;
    logic [15:0] lo;
    if (!mode) return 16'(a) * 16'(b);
    hi = '0;
    lo = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (a[k] & b[i]) begin
          if (i + k < cols) lo[i+k] = ~lo[i+k];
          else              hi = hi + (32'd1 << (i + k));
        end
      end
    end
    return hi[15:0] | lo;
  endfunction

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic mode,
                      input logic [15:0] e0, input logic [15:0] e4, input logic [15:0] e16);
    int unsigned waited;
    sb_t e;
    waited   = 0;
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus4.in_ready) begin
        e.e0 = e0; e.e4 = e4; e.e16 = e16; e.mode = mode;
        sb.push_back(e);
        n_accepted++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (rand_bp) out_ready = 1'b1;
      waited++;
      if (waited > 50) begin
        check_eq("in_ready_timeout", 32'(bus4.in_ready), 32'd1);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic send_model(input logic [7:0] a, input logic [7:0] b, input logic mode);
    send(a, b, mode, model(a, b, mode, 0), model(a, b, mode, 4), model(a, b, mode, 16));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_cnt = '0;
    end else begin
      check_eq("count0",  32'(bus0.approx_count),  32'(model_cnt));
      check_eq("count4",  32'(bus4.approx_count),  32'(model_cnt));
      check_eq("count16", 32'(bus16.approx_count), 32'(model_cnt));
      if (bus4.out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", 32'(bus4.out_valid), 32'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          n_pop++;
          check_eq("valid0",  32'(bus0.out_valid),  32'd1);
          check_eq("valid16", 32'(bus16.out_valid), 32'd1);
          check_eq("p0",  32'(bus0.out_p),  32'(e.e0));
          check_eq("p4",  32'(bus4.out_p),  32'(e.e4));
          check_eq("p16", 32'(bus16.out_p), 32'(e.e16));
          check_eq("mode4", 32'(bus4.out_mode), 32'(e.mode));
          if (e.mode && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned pop0;
    int unsigned acc0;

    // Reset state
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready",  32'(bus4.in_ready),     32'd1);
    check_eq("rst_out_valid", 32'(bus4.out_valid),    32'd0);
    check_eq("rst_out_p",     32'(bus4.out_p),        32'd0);
    check_eq("rst_count",     32'(bus4.approx_count), 32'd0);
    @(posedge clk); #1;

    // Exact FF*FF and its latency
    in_a = 8'hFF; in_b = 8'hFF; in_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check_eq("lat_in_ready", 32'(bus4.in_ready), 32'd1);
    begin
      sb_t e;
      e.e0 = 16'hFE01; e.e4 = 16'hFE01; e.e16 = 16'hFE01; e.mode = 1'b0;
      sb.push_back(e);
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
    end while (!bus4.out_valid && n < 10);
    check_eq("latency", n, 3);
    repeat (3) @(posedge clk); #1;

    // Approximate 0F*0F, then mixed modes back-to-back
    send(8'h0F, 8'h0F, 1'b1, 16'h00E1, 16'h00B5, 16'h0055);
    repeat (4) @(posedge clk); #1;
    send(8'h0F, 8'h0F, 1'b0, 16'h00E1, 16'h00E1, 16'h00E1);
    send(8'h0F, 8'h0F, 1'b1, 16'h00E1, 16'h00B5, 16'h0055);
    send(8'h0F, 8'h0F, 1'b0, 16'h00E1, 16'h00E1, 16'h00E1);
    send(8'h03, 8'h03, 1'b1, 16'h0009, 16'h0005, 16'h0005);
    repeat (5) @(posedge clk); #1;
    check_eq("mixed_drained", sb.size(), 0);

    // Backpressure: 5 inputs against a stalled output
    out_ready = 1'b0;
    acc0 = n_accepted;
    fork
      begin
        send_model(8'h12, 8'h34, 1'b0);
        send_model(8'hA5, 8'h5A, 1'b1);
        send_model(8'hFF, 8'h01, 1'b1);
        send_model(8'h80, 8'h80, 1'b0);
        send_model(8'h77, 8'hEE, 1'b1);
      end
      begin
        repeat (8) @(posedge clk);
        #2;
        check_eq("bp_accepted",  n_accepted - acc0, 3);
        check_eq("bp_in_ready",  32'(bus4.in_ready),  32'd0);
        check_eq("bp_out_valid", 32'(bus4.out_valid), 32'd1);
        check_eq("bp_hold_p",    32'(bus4.out_p),     32'(model(8'h12, 8'h34, 1'b0, 4)));
        pop0 = n_pop;
        out_ready = 1'b1;
        repeat (5) @(posedge clk); #1;
        check_eq("bp_drain_rate", n_pop - pop0, 5);
      end
    join
    repeat (2) @(posedge clk); #1;
    check_eq("bp_drained", sb.size(), 0);

    // Reset with a full pipe
    out_ready = 1'b0;
    send_model(8'h0F, 8'h0F, 1'b1);
    send_model(8'h11, 8'h22, 1'b1);
    send_model(8'h33, 8'h44, 1'b0);
    check_eq("pre_rst_valid", 32'(bus4.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(bus4.out_valid),    32'd0);
    check_eq("mid_rst_p",     32'(bus4.out_p),        32'd0);
    check_eq("mid_rst_count", 32'(bus4.approx_count), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("post_rst_idle", 32'(bus4.out_valid), 32'd0);
    end

    // Randomised sweep with corner operands and random backpressure
    rand_bp = 1'b1;
    send_model(8'h00, 8'hFF, 1'b1);
    send_model(8'hFF, 8'hFF, 1'b1);
    send_model(8'hFF, 8'h00, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
      send_model(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("final_drained", sb.size(), 0);
    repeat (2) @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
